spi_slave_responder: RTL and testbench

//   SD-card SPI-mode response generator; sits downstream of SpiSlaveReceiver.

---
 rtl/spi_slave_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_spi_slave_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_responder.sv
// ---------------------------------------------------------------------------
// spi_slave_responder
//
// SD-card SPI-mode response generator. It sits downstream of the SPI command
// receiver. Each decoded command is turned into an R1, R3 or R7 response,
// and the card init state is updated (idle flag, app-cmd prefix, ACMD41
// retry count). The response is then played out one byte per SPI byte slot
// to the MISO shift-out stage.
//
// Ports
//   clock                  in   system clock, rising edge
//   reset                  in   asynchronous, active-high
//   io_CommandReadFinished in   1-cycle pulse: a command frame is complete
//   io_ReadSuccess         in   frame valid qualifier for the pulse above
//   io_Command[5:0]        in   command index
//   io_CommandArgument     in   32-bit command argument
//   io_DataBlockSize       in   block length accepted by CMD16
//   io_ByteSlot            in   1-cycle pulse per completed SPI byte
//   io_TxByte[7:0]         out  byte for the next slot, 0xFF when silent
//   io_Responding          out  high while a response is pending or in flight
//   io_InIdle              out  card idle flag (R1 bit0)
//   io_AppCmd              out  next command is treated as ACMDn
//   io___state[1:0]        out  debug FSM state: 0 IDLE, 1 WAIT_NCR, 2 SEND
//
// Handshake: a command is accepted on any cycle where io_CommandReadFinished
// is high and the frame is usable. Acceptance always pre-empts a response in
// progress. It also masks a coincident io_ByteSlot, so that slot is not
// counted. io_ByteSlot has no back-pressure: every pulse advances the FSM by
// exactly one byte.
//
// Optional feature macro: SPI_RESP_CRC_ERR_EN
//   When defined, an invalid frame (io_ReadSuccess=0) is answered with an R1
//   carrying the CRC-error bit, and only AppCmd is cleared. When undefined,
//   invalid frames are ignored.
// ---------------------------------------------------------------------------
module spi_slave_responder #(
    parameter int          NCR_BYTES      = 1,
    parameter int          ACMD41_RETRIES = 2,
    parameter logic [31:0] OCR_VALUE      = 32'h00FF8000,
    parameter int          BLKSZ_W        = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               io_CommandReadFinished,
    input  logic               io_ReadSuccess,
    input  logic [5:0]         io_Command,
    input  logic [31:0]        io_CommandArgument,
    input  logic [BLKSZ_W-1:0] io_DataBlockSize,
    input  logic               io_ByteSlot,
    output logic [7:0]         io_TxByte,
    output logic               io_Responding,
    output logic               io_InIdle,
    output logic               io_AppCmd,
    output logic [1:0]         io___state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_NCR = 2'd1,
        ST_SEND     = 2'd2
    } state_t;

    localparam logic [3:0] NCR_LAST  = 4'(NCR_BYTES);
    localparam logic [7:0] RETRY_MAX = 8'(ACMD41_RETRIES);

    state_t      state_q, state_d;
    logic [7:0]  tx_q, tx_d;
    logic [39:0] resp_q, resp_d;   // pending bytes, next byte in [39:32]
    logic [2:0]  rem_q, rem_d;     // bytes still to send after the current one
    logic [3:0]  cnt_q, cnt_d;     // NCR filler slots seen so far
    logic        idle_q, idle_d;
    logic        app_q, app_d;
    logic [7:0]  retry_q, retry_d;

    logic        accept;
    logic [39:0] dec_word;
    logic [2:0]  dec_rem;
    logic        dec_idle;
    logic        dec_app;
    logic [7:0]  dec_retry;
    logic        param_err;
    logic        crc_err;
    logic        illegal;
    logic [7:0]  r1;
    logic [31:0] ocr;

`ifdef SPI_RESP_CRC_ERR_EN
    assign accept = io_CommandReadFinished;
`else
    assign accept = io_CommandReadFinished && io_ReadSuccess;
`endif

    // Command decode: the response and the card state after this command.
    // The R1 idle bit reflects the idle flag after the update.
    always_comb begin
        dec_idle  = idle_q;
        dec_app   = 1'b0;
        dec_retry = retry_q;
        dec_rem   = 3'd0;
        param_err = 1'b0;
        crc_err   = 1'b0;
        illegal   = 1'b0;
        ocr       = OCR_VALUE;
        r1        = 8'h00;
        dec_word  = 40'hFF_FFFF_FFFF;

`ifdef SPI_RESP_CRC_ERR_EN
        if (!io_ReadSuccess) begin
            crc_err = 1'b1;
        end else
`endif
        begin
            case (io_Command)
                6'd0: begin
                    dec_idle  = 1'b1;
                    dec_retry = 8'd0;
                end
                6'd8: begin
                    dec_rem = 3'd4;
                end
                6'd55: begin
                    dec_app = 1'b1;
                end
                6'd41: begin
                    if (!app_q) begin
                        illegal = 1'b1;
                    end else if (retry_q < RETRY_MAX) begin
                        dec_retry = retry_q + 8'd1;
                    end else begin
                        dec_idle = 1'b0;
                    end
                end
                6'd16: begin
                    param_err = (io_CommandArgument != 32'(io_DataBlockSize));
                end
                6'd58: begin
                    dec_rem = 3'd4;
                end
                default: begin
                    illegal = 1'b1;
                end
            endcase
        end

        r1 = {1'b0, param_err, 2'b00, crc_err, illegal, 1'b0, dec_idle};
        // Once the card leaves idle, OCR bit31 reports power-up complete.
        ocr[31] = ~dec_idle;

        if (dec_rem == 3'd0) begin
            dec_word = {r1, 32'hFFFF_FFFF};
        end else if (io_Command == 6'd8) begin
            dec_word = {r1, 8'h00, 8'h00, 4'h0, io_CommandArgument[11:8],
                        io_CommandArgument[7:0]};
        end else begin
            dec_word = {r1, ocr};
        end
    end

    // Next-state and output logic. Acceptance has priority over a slot.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        resp_d  = resp_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        app_d   = app_q;
        retry_d = retry_q;

        if (accept) begin
            state_d = ST_WAIT_NCR;
            tx_d    = 8'hFF;
            resp_d  = dec_word;
            rem_d   = dec_rem;
            cnt_d   = 4'd0;
            idle_d  = dec_idle;
            app_d   = dec_app;
            retry_d = dec_retry;
        end else if (io_ByteSlot) begin
            case (state_q)
                ST_WAIT_NCR: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == NCR_LAST) begin
                        state_d = ST_SEND;
                        tx_d    = resp_q[39:32];
                        resp_d  = {resp_q[31:0], 8'hFF};
                    end
                end
                ST_SEND: begin
                    if (rem_q == 3'd0) begin
                        state_d = ST_IDLE;
                        tx_d    = 8'hFF;
                    end else begin
                        tx_d   = resp_q[39:32];
                        resp_d = {resp_q[31:0], 8'hFF};
                        rem_d  = rem_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tx_q    <= 8'hFF;
            resp_q  <= 40'hFF_FFFF_FFFF;
            rem_q   <= 3'd0;
            cnt_q   <= 4'd0;
            idle_q  <= 1'b1;
            app_q   <= 1'b0;
            retry_q <= 8'd0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            resp_q  <= resp_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            app_q   <= app_d;
            retry_q <= retry_d;
        end
    end

    assign io_TxByte     = tx_q;
    assign io_Responding = (state_q != ST_IDLE);
    assign io_InIdle     = idle_q;
    assign io_AppCmd     = app_q;
    assign io___state    = state_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_responder
//
// Directed bench for spi_slave_responder. Driver tasks issue commands and
// byte slots on the falling edge. Every slot pushes its expected
// {io_Responding, io_TxByte} pair into exp_q. A monitor pops and compares one
// entry just after each rising edge that carries a slot pulse. Status flags
// are compared directly after commands.
// OCR_VALUE is set to 32'h40FF8000, so CMD58 after init reads C0 FF 80 00.
// ---------------------------------------------------------------------------
module tb_spi_slave_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_fin;
    logic        read_ok;
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic [11:0] blksz;
    logic        slot;
    logic [7:0]  tx_byte;
    logic        responding;
    logic        in_idle;
    logic        app_cmd;
    logic [1:0]  dbg_state;

    logic [8:0]  exp_q[$];
    logic [8:0]  mon_exp;
    int          checks   = 0;
    int          failures = 0;

    spi_slave_responder #(
        .NCR_BYTES      (1),
        .ACMD41_RETRIES (2),
        .OCR_VALUE      (32'h40FF8000),
        .BLKSZ_W        (12)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .io_CommandReadFinished (cmd_fin),
        .io_ReadSuccess         (read_ok),
        .io_Command             (cmd),
        .io_CommandArgument     (arg),
        .io_DataBlockSize       (blksz),
        .io_ByteSlot            (slot),
        .io_TxByte              (tx_byte),
        .io_Responding          (responding),
        .io_InIdle              (in_idle),
        .io_AppCmd              (app_cmd),
        .io___state             (dbg_state)
    );

    // Clock / reset.
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: one expected entry per slot pulse.
    always @(posedge clock) begin
        if (slot === 1'b1 && reset === 1'b0) begin
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_slot: got %h required none",
                         {responding, tx_byte});
            end else begin
                mon_exp = exp_q.pop_front();
                check("slot_byte", {23'd0, responding, tx_byte}, {23'd0, mon_exp});
            end
        end
    end

    // Drivers (called on the falling edge, return on the falling edge).
    task automatic issue_cmd(input logic [5:0] c, input logic [31:0] a,
                             input logic ok);
        cmd     = c;
        arg     = a;
        read_ok = ok;
        cmd_fin = 1'b1;
        @(negedge clock);
        cmd_fin = 1'b0;
        read_ok = 1'b1;
        @(negedge clock);
    endtask

    task automatic issue_cmd_slot(input logic [5:0] c, input logic [31:0] a,
                                  input logic [8:0] exp);
        exp_q.push_back(exp);
        cmd     = c;
        arg     = a;
        read_ok = 1'b1;
        cmd_fin = 1'b1;
        slot    = 1'b1;
        @(negedge clock);
        cmd_fin = 1'b0;
        slot    = 1'b0;
        @(negedge clock);
    endtask

    task automatic do_slot(input logic [7:0] b, input logic resp);
        exp_q.push_back({resp, b});
        slot = 1'b1;
        @(negedge clock);
        slot = 1'b0;
        @(negedge clock);
    endtask

    // Full response: n bytes from b (MSB first), then the closing FF slot.
    task automatic expect_resp(input logic [39:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            do_slot(b[39-8*i -: 8], 1'b1);
        end
        do_slot(8'hFF, 1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        cmd_fin = 1'b0;
        read_ok = 1'b1;
        cmd     = 6'd0;
        arg     = 32'd0;
        blksz   = 12'd512;
        slot    = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("reset_tx", {24'd0, tx_byte}, 32'hFF);
        check("reset_resp", {31'd0, responding}, 32'd0);
        check("reset_idle", {31'd0, in_idle}, 32'd1);
        check("reset_app", {31'd0, app_cmd}, 32'd0);
        check("reset_state", {30'd0, dbg_state}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // CMD0: FF (before any slot), 01, FF, and an extra idle slot.
        issue_cmd(6'd0, 32'd0, 1'b1);
        check("cmd0_responding", {31'd0, responding}, 32'd1);
        check("cmd0_state", {30'd0, dbg_state}, 32'd1);
        check("cmd0_tx_ncr", {24'd0, tx_byte}, 32'hFF);
        expect_resp(40'h01_0000_0000, 1);
        do_slot(8'hFF, 1'b0);
        check("cmd0_idle", {31'd0, in_idle}, 32'd1);

        // CMD8 R7 echo.
        issue_cmd(6'd8, 32'h0000_01AA, 1'b1);
        expect_resp(40'h01_0000_01AA, 5);

        // ACMD41 init loop: busy, busy, ready.
        for (int k = 0; k < 3; k++) begin
            issue_cmd(6'd55, 32'd0, 1'b1);
            check("cmd55_app", {31'd0, app_cmd}, 32'd1);
            expect_resp(40'h01_0000_0000, 1);
            issue_cmd(6'd41, 32'h4000_0000, 1'b1);
            check("acmd41_app_clr", {31'd0, app_cmd}, 32'd0);
            expect_resp((k < 2) ? 40'h01_0000_0000 : 40'h00_0000_0000, 1);
        end
        check("acmd41_idle", {31'd0, in_idle}, 32'd0);

        // CMD58 R3 with bit31 set.
        issue_cmd(6'd58, 32'd0, 1'b1);
        expect_resp(40'h00_C0FF_8000, 5);

        // CMD16 match / mismatch, CMD41 without prefix.
        issue_cmd(6'd16, 32'd512, 1'b1);
        expect_resp(40'h00_0000_0000, 1);
        issue_cmd(6'd16, 32'd1024, 1'b1);
        expect_resp(40'h40_0000_0000, 1);
        issue_cmd(6'd41, 32'd0, 1'b1);
        expect_resp(40'h04_0000_0000, 1);
        issue_cmd(6'd0, 32'd0, 1'b1);
        expect_resp(40'h01_0000_0000, 1);
        issue_cmd(6'd41, 32'd0, 1'b1);
        expect_resp(40'h05_0000_0000, 1);
        // The retry count was cleared by CMD0, so ACMD41 is busy again.
        issue_cmd(6'd55, 32'd0, 1'b1);
        expect_resp(40'h01_0000_0000, 1);
        issue_cmd(6'd41, 32'd0, 1'b1);
        expect_resp(40'h01_0000_0000, 1);
        check("retry_restart_idle", {31'd0, in_idle}, 32'd1);

        // Pre-emption: CMD8 after 2 bytes, CMD0 lands on a slot.
        issue_cmd(6'd8, 32'h0000_01AA, 1'b1);
        do_slot(8'h01, 1'b1);
        do_slot(8'h00, 1'b1);
        issue_cmd_slot(6'd0, 32'd0, {1'b1, 8'hFF});
        check("preempt_state", {30'd0, dbg_state}, 32'd1);
        expect_resp(40'h01_0000_0000, 1);

        // Invalid frame behaviour.
        issue_cmd(6'd55, 32'd0, 1'b1);
        expect_resp(40'h01_0000_0000, 1);
        issue_cmd(6'd0, 32'd0, 1'b0);
`ifdef SPI_RESP_CRC_ERR_EN
        check("crc_app_clr", {31'd0, app_cmd}, 32'd0);
        check("crc_responding", {31'd0, responding}, 32'd1);
        expect_resp(40'h09_0000_0000, 1);
`else
        check("bad_frame_app", {31'd0, app_cmd}, 32'd1);
        check("bad_frame_resp", {31'd0, responding}, 32'd0);
        check("bad_frame_tx", {24'd0, tx_byte}, 32'hFF);
        do_slot(8'hFF, 1'b0);
`endif

        // Reset in the middle of a response.
        issue_cmd(6'd55, 32'd0, 1'b1);
        do_slot(8'h01, 1'b1);
        reset = 1'b1;
        #1;
        check("midrst_tx", {24'd0, tx_byte}, 32'hFF);
        check("midrst_resp", {31'd0, responding}, 32'd0);
        check("midrst_app", {31'd0, app_cmd}, 32'd0);
        check("midrst_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        issue_cmd(6'd0, 32'd0, 1'b1);
        expect_resp(40'h01_0000_0000, 1);

        repeat (3) @(negedge clock);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
